// File: rtl/ws2812_tx.sv
// ws2812_tx: WS2812 one-wire NRZ transmitter for the 8x8 snake display matrix.
// It walks the pixel and bit counters that address the frame-content block and
// samples the returned bit. Each frame goes out GRB MSB-first and is followed
// by a low latch gap.
// Build option: define AUTO_REFRESH_EN to make frames repeat back-to-back after
// the first accepted start. When it is undefined, one frame is sent per start.
//
// state | meaning
// IDLE  | line low, waiting for start
// SEND  | shifting frame bits, one TBIT_CYC period per bit
// LATCH | line held low for RST_CYC clocks so the LEDs latch the frame
module ws2812_tx #(
  parameter int PIXEL_NUM = 64,
  parameter int BIT_NUM   = 24,
  parameter int TBIT_CYC  = 60,
  parameter int T0H_CYC   = 15,
  parameter int T1H_CYC   = 35,
  parameter int RST_CYC   = 15000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       data_bit,
  output logic [4:0] cnt_bit,
  output logic [6:0] cnt_pixel,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int CYC_MAX = (TBIT_CYC > RST_CYC) ? TBIT_CYC : RST_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cyc;
  logic             bit_q;
  logic             cur_bit;
  logic [CYC_W-1:0] thr;
  logic             bit_end;
  logic             last_bit;
  logic             latch_end;

  // Current bit value and high-time threshold. On cyc==0 the bit comes
  // straight from data_bit so the first high clock is not lost. After that,
  // the captured copy keeps the bit immune to data_bit changes.
  always_comb begin
    cur_bit   = (cyc == '0) ? data_bit : bit_q;
    thr       = cur_bit ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC);
    bit_end   = (cyc == CYC_W'(TBIT_CYC - 1));
    last_bit  = (cnt_bit == 5'(BIT_NUM - 1)) && (cnt_pixel == 7'(PIXEL_NUM - 1));
    latch_end = (cyc == CYC_W'(RST_CYC - 1));
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state decode, busy and the frame_done pulse
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (start) state_nxt = SEND;
      SEND:  if (bit_end && last_bit) state_nxt = LATCH;
      LATCH: begin
        if (latch_end) begin
          frame_done = 1'b1;
`ifdef AUTO_REFRESH_EN
          state_nxt  = SEND;
`else
          state_nxt  = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle and address counters, bit capture and registered line output
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cyc       <= '0;
      cnt_bit   <= '0;
      cnt_pixel <= '0;
      dout      <= 1'b0;
      bit_q     <= 1'b0;
    end else begin
      case (state)
        SEND: begin
          dout <= (cyc < thr);
          if (cyc == '0) bit_q <= data_bit;
          if (bit_end) begin
            cyc <= '0;
            if (cnt_bit == 5'(BIT_NUM - 1)) begin
              cnt_bit <= '0;
              if (cnt_pixel == 7'(PIXEL_NUM - 1)) cnt_pixel <= '0;
              else                                cnt_pixel <= cnt_pixel + 7'd1;
            end else begin
              cnt_bit <= cnt_bit + 5'd1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        LATCH: begin
          dout <= 1'b0;
          if (latch_end) cyc <= '0;
          else           cyc <= cyc + 1'b1;
        end
        default: begin
          dout      <= 1'b0;
          cyc       <= '0;
          cnt_bit   <= '0;
          cnt_pixel <= '0;
        end
      endcase
    end
  end

endmodule
